// File: rtl/disparity_scan_ctrl_if.sv
// Control/result bus between the disparity scan sequencer and the correlation calc unit.
// The sequencer owns the strobes and candidate offset; the calc unit returns score and tag.
interface disparity_scan_ctrl_if;
  logic [7:0]  startplace;
  logic        startsig;
  logic        work;
  logic        valid;
  logic        finalstart;
  logic        change;
  logic [17:0] result;
  logic [7:0]  place;

  modport master (
    output startplace, startsig, work, valid, finalstart, change,
    input  result, place
  );

  modport slave (
    input  startplace, startsig, work, valid, finalstart, change,
    output result, place
  );
endinterface

// File: rtl/disparity_scan_ctrl.sv
// Disparity scan sequencer: steps the calc unit through N_DISP candidate offsets,
// meters WIN_LEN pixel pairs per window and tracks the best-scoring offset.
module disparity_scan_ctrl #(
  parameter int WIN_LEN = 16,
  parameter int N_DISP  = 32,
  parameter int LAT     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         go,
  input  logic [7:0]                   base_place,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  disparity_scan_ctrl_if.master        calc,
  output logic                         busy,
  output logic                         done,
  output logic [17:0]                  best_result,
  output logic [7:0]                   best_place,
  output logic                         tag_err
);

  localparam int CNT_W  = $clog2(WIN_LEN + 1);
  localparam int WCNT_W = (LAT > 1) ? $clog2(LAT + 1) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIN_LEN - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(LAT - 1);
  localparam logic [7:0]        IDX_LAST  = 8'(N_DISP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACCUM,
    S_FINAL,
    S_WAIT,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [WCNT_W-1:0] wcnt;
  logic [7:0]        idx;
  logic [7:0]        startplace_q;
  logic              first;
  logic              take_result;

  // A candidate wins only on a strictly larger score, so ties keep the earliest offset.
  assign take_result = first || (calc.result > best_result);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next        = state;
    calc.startsig     = 1'b0;
    calc.work         = 1'b0;
    calc.valid        = 1'b0;
    calc.finalstart   = 1'b0;
    calc.change       = 1'b0;
    done              = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        calc.startsig = 1'b1;
        state_next    = S_ACCUM;
      end
      S_ACCUM: begin
        calc.work = 1'b1;
        if (pix_valid) begin
          calc.valid = 1'b1;
          if (cnt == CNT_LAST) begin
            state_next = S_FINAL;
          end
        end
      end
      S_FINAL: begin
        calc.finalstart = 1'b1;
        state_next      = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt == WCNT_LAST) begin
          state_next = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (idx != IDX_LAST) begin
          calc.change = 1'b1;
          state_next  = S_LOAD;
        end else begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign pix_ready       = calc.valid;
  assign busy            = (state != S_IDLE);
  assign calc.startplace = startplace_q;

  // startplace advances by one per candidate, which equals base_place + idx modulo 256.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      wcnt         <= '0;
      idx          <= '0;
      startplace_q <= '0;
      first        <= 1'b0;
      best_result  <= '0;
      best_place   <= '0;
      tag_err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            startplace_q <= base_place;
            idx          <= '0;
            first        <= 1'b1;
            best_result  <= '0;
            best_place   <= '0;
            tag_err      <= 1'b0;
          end
        end
        S_LOAD: begin
          cnt <= '0;
        end
        S_ACCUM: begin
          if (pix_valid) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FINAL: begin
          wcnt <= '0;
        end
        S_WAIT: begin
          wcnt <= wcnt + 1'b1;
        end
        S_COMPARE: begin
          if (take_result) begin
            best_result <= calc.result;
            best_place  <= startplace_q;
          end
          first <= 1'b0;
          if (calc.place != startplace_q) begin
            tag_err <= 1'b1;
          end
          if (idx != IDX_LAST) begin
            idx          <= idx + 1'b1;
            startplace_q <= startplace_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disparity_scan_ctrl.sv
// Self-checking bench for disparity_scan_ctrl: directed searches against a scoreboard of
// expected candidate offsets and best score/place per search.
module tb_disparity_scan_ctrl;

  localparam int WIN_LEN = 16;
  localparam int N_DISP  = 4;
  localparam int LAT     = 3;

  typedef struct {
    logic [17:0] r;
    logic [7:0]  p;
    logic        t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic [7:0]  base_place = 8'h00;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic        busy;
  logic        done;
  logic [17:0] best_result;
  logic [7:0]  best_place;
  logic        tag_err;

  disparity_scan_ctrl_if calc();

  disparity_scan_ctrl #(
    .WIN_LEN(WIN_LEN),
    .N_DISP (N_DISP),
    .LAT    (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .base_place (base_place),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .calc       (calc),
    .busy       (busy),
    .done       (done),
    .best_result(best_result),
    .best_place (best_place),
    .tag_err    (tag_err)
  );

  initial forever #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          ss_count = 0;
  int          vcnt = 0;
  int          cyc = 0;
  int          chg_count = 0;
  logic        prev_valid = 1'b0;
  logic        pix_mode = 1'b0;
  logic        in_search = 1'b0;
  logic [7:0]  place_off = 8'h00;
  logic [7:0]  base_cur = 8'h00;
  logic [7:0]  cur_sp = 8'h00;
  logic [17:0] scores [N_DISP];
  logic [7:0]  exp_sp_q [$];
  exp_t        best_q [$];
  exp_t        last_exp;

  // Calc unit stand-in: score keyed by candidate offset, tag optionally skewed.
  logic [7:0] cand;
  assign cand        = calc.startplace - base_cur;
  assign calc.result = (cand < 8'(N_DISP)) ? scores[cand[1:0]] : 18'h3FFFF;
  assign calc.place  = calc.startplace + place_off;

  initial forever begin
    @(posedge clk);
    #1;
    pix_valid = pix_mode ? ~pix_valid : 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy_done"}, {busy, done}, 0);
    checkOutput({tag, "_strobes"}, {pix_ready, calc.startsig, calc.work, calc.valid,
                                    calc.finalstart, calc.change}, 0);
    checkOutput({tag, "_startplace"}, calc.startplace, 0);
    checkOutput({tag, "_best"}, {tag_err, best_place, best_result}, 0);
  endtask

  task automatic applyStimulus(input logic [7:0] base, input logic [17:0] s0,
                               input logic [17:0] s1, input logic [17:0] s2,
                               input logic [17:0] s3, input logic toggle,
                               input logic [7:0] poff);
    exp_t e;
    scores[0] = s0;
    scores[1] = s1;
    scores[2] = s2;
    scores[3] = s3;
    pix_mode  = toggle;
    place_off = poff;
    base_cur  = base;
    e.r = s0;
    e.p = base;
    for (int i = 1; i < N_DISP; i++) begin
      if (scores[i] > e.r) begin
        e.r = scores[i];
        e.p = base + 8'(i);
      end
    end
    e.t = (poff != 8'h00);
    best_q.push_back(e);
    last_exp = e;
    for (int i = 0; i < N_DISP; i++) exp_sp_q.push_back(base + 8'(i));
    ss_count   = 0;
    in_search  = 1'b1;
    base_place = base;
    go         = 1'b1;
    @(posedge clk);
    #1;
    go         = 1'b0;
    base_place = 8'hAA;
  endtask

  task automatic waitStartsigs(input int n);
    int k = 0;
    while (ss_count < n && k < 500) begin
      @(negedge clk);
      #1;
      k++;
    end
    checkOutput("startsig_timeout", (ss_count >= n), 1);
  endtask

  task automatic waitDone(input logic go_at_done);
    logic found = 1'b0;
    for (int k = 0; k < 1000 && !found; k++) begin
      @(posedge clk);
      #1;
      if (done) found = 1'b1;
    end
    checkOutput("done_timeout", found, 1);
    if (go_at_done) go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    checkOutput("done_one_cycle", done, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("best_hold", {best_result, best_place}, {last_exp.r, last_exp.p});
  endtask

  // Monitor: samples on the falling edge and pops scoreboard entries as the DUT reports.
  always @(negedge clk) begin
    if (rst) begin
      vcnt       = 0;
      cyc        = 0;
      chg_count  = 0;
      prev_valid = 1'b0;
    end else begin
      cyc++;
      if (calc.startsig) begin
        checkOutput("startsig_expected", (exp_sp_q.size() != 0), 1);
        if (exp_sp_q.size() != 0) begin
          cur_sp = exp_sp_q.pop_front();
          checkOutput("startplace", calc.startplace, cur_sp);
        end
        ss_count++;
        vcnt = 0;
        cyc  = 0;
      end
      if (!in_search) checkOutput("idle_ready", {pix_ready, calc.valid}, 0);
      if (!pix_valid) checkOutput("stall_ready", pix_ready, 0);
      if (calc.valid) vcnt++;
      if (calc.finalstart) begin
        checkOutput("valid_count", vcnt, WIN_LEN);
        checkOutput("final_after_last", prev_valid, 1);
        checkOutput("final_place", calc.startplace, cur_sp);
      end
      if (calc.change) begin
        chg_count++;
        if (!pix_mode) checkOutput("cand_cycles", cyc, 1 + WIN_LEN + 1 + LAT);
      end
      if (done) begin
        checkOutput("done_expected", (best_q.size() != 0), 1);
        if (best_q.size() != 0) begin
          exp_t e;
          e = best_q.pop_front();
          checkOutput("best_result", best_result, e.r);
          checkOutput("best_place", best_place, e.p);
          checkOutput("tag_err", tag_err, e.t);
        end
        if (!pix_mode) checkOutput("last_cand_cycles", cyc, 1 + WIN_LEN + 1 + LAT + 1);
        checkOutput("change_count", chg_count, N_DISP - 1);
        chg_count = 0;
        in_search = 1'b0;
      end
      prev_valid = calc.valid;
    end
  end

  initial begin
    for (int i = 0; i < N_DISP; i++) scores[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] test 1: ascending scores, base 10");
    applyStimulus(8'd10, 18'd0, 18'd100, 18'd200, 18'd300, 1'b0, 8'd0);
    checkOutput("busy_after_go", busy, 1);
    waitDone(1'b0);
    checkOutput("t1_best", {best_result, best_place}, {18'd300, 8'd13});

    $display("[TB] test 2: tie keeps first, go ignored mid-search and at done");
    applyStimulus(8'd40, 18'd50, 18'd90, 18'd90, 18'd20, 1'b0, 8'd0);
    repeat (6) @(posedge clk);
    #1;
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    waitDone(1'b1);
    checkOutput("t2_best", {best_result, best_place}, {18'd90, 8'd41});

    $display("[TB] test 3: pix_valid toggling");
    applyStimulus(8'd5, 18'd7, 18'd3, 18'd9, 18'd8, 1'b1, 8'd0);
    waitDone(1'b0);

    $display("[TB] test 4: startplace wraps from 254");
    applyStimulus(8'd254, 18'd1, 18'd2, 18'd3, 18'h3FFFE, 1'b0, 8'd0);
    waitDone(1'b0);
    checkOutput("t4_best_place", best_place, 8'd1);

    $display("[TB] test 5: reset during second candidate");
    applyStimulus(8'd100, 18'd5, 18'd6, 18'd7, 18'd8, 1'b0, 8'd0);
    waitStartsigs(2);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_sp_q.delete();
    best_q.delete();
    in_search = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkResetOutputs("midreset");
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    applyStimulus(8'd100, 18'd5, 18'd600, 18'd7, 18'd8, 1'b0, 8'd0);
    waitDone(1'b0);

    $display("[TB] test 6: place tag mismatch");
    applyStimulus(8'd20, 18'd4, 18'd3, 18'd2, 18'd1, 1'b0, 8'd1);
    waitStartsigs(1);
    checkOutput("tag_before_compare", tag_err, 0);
    waitStartsigs(2);
    checkOutput("tag_after_compare", tag_err, 1);
    waitDone(1'b0);
    checkOutput("tag_sticky", tag_err, 1);
    applyStimulus(8'd20, 18'd4, 18'd3, 18'd2, 18'd1, 1'b0, 8'd0);
    checkOutput("tag_cleared_by_go", tag_err, 0);
    waitDone(1'b0);

    $display("[TB] test 7: all-zero scores");
    applyStimulus(8'd77, 18'd0, 18'd0, 18'd0, 18'd0, 1'b0, 8'd0);
    waitDone(1'b0);
    checkOutput("t7_best", {best_result, best_place}, {18'd0, 8'd77});

    repeat (5) @(posedge clk);
    #1;
    checkOutput("queues_drained", exp_sp_q.size() + best_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
